fp_itof: RTL and testbench

- Pipelined signed/unsigned 32-bit integer to IEEE-754 single-precision converter.
- Inverse of the fp32 float-to-int unit; lives in rtl/fp32_core beside it and serves the ALU conversion path (I2F opcodes).
- Rounding is round-to-nearest-even; the inexact flag is reported.
- Three register stages with valid/ready handshake and per-stage bubble collapse.

---
 rtl/fp_itof_pkg.sv | 31 +++
 rtl/fp_lzc32.sv | 18 +
 rtl/fp_itof.sv | 112 +++++++++++
 tb/tb_fp_itof.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_itof_pkg.sv
// Shared fp32 field widths, the packed fp32 type and the integer-to-float stage payloads.
package fp_itof_pkg;

    localparam int FP_DATA_W = 32;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_BIAS   = 127;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam fp32_t FP32_POS_ZERO = '0;

    typedef struct packed {
        logic        sign;
        logic        zero;
        logic [31:0] mag;
    } itof_s1_t;

    // The leading one is implicit after normalization, so only bits below it are kept.
    typedef struct packed {
        logic        sign;
        logic        zero;
        logic [30:0] norm;
        logic [7:0]  exp;
    } itof_s2_t;

endpackage

// File: rtl/fp_lzc32.sv
// Combinational 32-bit leading-zero counter with an all-zero flag.
module fp_lzc32 (
    input  logic [31:0] val,
    output logic [5:0]  cnt,
    output logic        all_zero
);

    // Later iterations win, so the highest set bit decides the count.
    always_comb begin
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            if (val[i]) cnt = 6'(31 - i);
        end
    end

    assign all_zero = (val == 32'd0);

endmodule

// File: rtl/fp_itof.sv
// Three-stage signed/unsigned int32 to fp32 converter, round-to-nearest-even, with
// valid/ready flow control and bubble collapse at every stage.
module fp_itof
    import fp_itof_pkg::*;
#(
    parameter int DATA_WIDTH = FP_DATA_W,
    parameter int EXP_WIDTH  = FP_EXP_W,
    parameter int MANT_WIDTH = FP_MANT_W,
    parameter int BIAS       = FP_BIAS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] int_in,
    input  logic                  is_unsigned,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] float_result,
    output logic                  inexact
);

    if (DATA_WIDTH != 32 || EXP_WIDTH != 8 || MANT_WIDTH != 23) begin : g_bad_cfg
        $fatal(1, "fp_itof supports only 32-bit operands with an 8/23 fp32 layout");
    end

    logic     v1, v2, v3;
    logic     rdy1, rdy2, rdy3;
    itof_s1_t s1_d, s1_q;
    itof_s2_t s2_d, s2_q;
    fp32_t    res_d, res_q;
    logic     inx_d, inx_q;
    logic [5:0] lzc;
    logic       lz_zero;

    // An empty stage always loads, so a bubble is absorbed even under a stall.
    assign rdy3     = !v3 || out_ready;
    assign rdy2     = !v2 || rdy3;
    assign rdy1     = !v1 || rdy2;
    assign in_ready = rdy1;

    // S1: sign and magnitude; 0x80000000 negates to itself, which reads as 2^31.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = !is_unsigned && int_in[31];
        s1_d.mag  = s1_d.sign ? (~int_in + 32'd1) : int_in;
        s1_d.zero = (int_in == '0);
    end

    fp_lzc32 u_lzc (
        .val      (s1_q.mag),
        .cnt      (lzc),
        .all_zero (lz_zero)
    );

    // S2: normalize so the leading one lands in bit 31.
    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.zero = s1_q.zero;
        s2_d.norm = 31'(s1_q.mag << lzc);
        s2_d.exp  = lz_zero ? 8'd0 : 8'(BIAS + 31) - {2'b00, lzc};
    end

    // S3: round to nearest even; a mantissa carry only bumps the exponent (max 159).
    logic [22:0] mant;
    logic        guard, sticky, rnd_up;
    logic [23:0] mant_rnd;

    always_comb begin
        mant     = s2_q.norm[30:8];
        guard    = s2_q.norm[7];
        sticky   = |s2_q.norm[6:0];
        rnd_up   = guard && (sticky || mant[0]);
        mant_rnd = {1'b0, mant} + {23'd0, rnd_up};
        res_d.sign = s2_q.sign;
        res_d.exp  = s2_q.exp + {7'd0, mant_rnd[23]};
        res_d.mant = mant_rnd[22:0];
        inx_d      = guard || sticky;
        if (s2_q.zero) begin
            res_d = FP32_POS_ZERO;
            inx_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            res_q <= '0;
            inx_q <= 1'b0;
        end else begin
            if (rdy1) v1 <= in_valid;
            if (rdy1 && in_valid) s1_q <= s1_d;
            if (rdy2) v2 <= v1;
            if (rdy2 && v1) s2_q <= s2_d;
            if (rdy3) v3 <= v2;
            if (rdy3 && v2) begin
                res_q <= res_d;
                inx_q <= inx_d;
            end
        end
    end

    assign out_valid    = v3;
    assign float_result = res_q;
    assign inexact      = inx_q;

endmodule

// File: tb/tb_fp_itof.sv
// Directed and randomized bench for fp_itof against an arithmetic int-to-fp32 reference.
module tb_fp_itof;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] int_in;
    logic        is_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] float_result;
    logic        inexact;

    fp_itof dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .int_in       (int_in),
        .is_unsigned  (is_unsigned),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .float_result (float_result),
        .inexact      (inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        inx;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    logic        lat_en = 1'b0;
    logic        rand_or = 1'b0;
    logic        acc = 1'b0;
    logic [31:0] nxt_res = '0;
    logic        nxt_inx = 1'b0;
    logic [31:0] held;

    // Value-level reference: round the exact magnitude by division and remainder.
    function automatic logic [32:0] ref_conv(input logic [31:0] x, input logic u);
        longint m, p, q, rem;
        int     e;
        logic   s, inx;
        s = !u && x[31];
        m = longint'({32'd0, x});
        if (s) m = 64'sh1_0000_0000 - m;
        if (m == 0) return 33'd0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        inx = 1'b0;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            p   = longint'(1) << (e - 23);
            q   = m / p;
            rem = m % p;
            inx = (rem != 0);
            if (rem * 2 > p || (rem * 2 == p && q[0])) q++;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e++;
            end
        end
        return {inx, s, 8'(e + 127), q[22:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // One clock: sample both handshakes just before the edge, score outputs, advance.
    task automatic cycle();
        exp_t e;
        if (rand_or) out_ready = ($urandom_range(0, 2) != 0);
        #2;
        acc = rst && in_valid && in_ready;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("result", 64'(float_result), 64'(e.res));
                check("inexact", 64'(inexact), 64'(e.inx));
                if (lat_en) check("latency", 64'(cyc - e.cyc), 64'(3));
            end
        end
        if (acc) begin
            e.res = nxt_res;
            e.inx = nxt_inx;
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [31:0] x, input logic u, input logic [31:0] r, input logic i);
        int_in      = x;
        is_unsigned = u;
        in_valid    = 1'b1;
        nxt_res     = r;
        nxt_inx     = i;
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (acc) break;
        end
        if (!acc) check("accept_timeout", 64'(acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] x, input logic u);
        logic [32:0] r;
        r = ref_conv(x, u);
        send(x, u, r[31:0], r[32]);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) cycle();
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [31:0] x;
        rst = 1'b1; in_valid = 1'b0; int_in = '0; is_unsigned = 1'b0; out_ready = 1'b1;
        #2;
        // Reset held with a valid input presented: nothing may be captured.
        rst = 1'b0; in_valid = 1'b1; int_in = 32'd7;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_result", 64'(float_result), 64'(0));
            check("rst_inexact", 64'(inexact), 64'(0));
            cycle();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("post_rst_idle", 64'(out_valid), 64'(0));
            cycle();
        end

        // Exact and rounding vectors, back to back, fixed three-cycle latency.
        lat_en = 1'b1;
        send(32'd7,         1'b0, 32'h40E0_0000, 1'b0);
        send(32'hFFFF_FFFF, 1'b0, 32'hBF80_0000, 1'b0);
        send(32'h8000_0000, 1'b0, 32'hCF00_0000, 1'b0);
        send(32'd0,         1'b0, 32'h0000_0000, 1'b0);
        send(32'd16777217,  1'b0, 32'h4B80_0000, 1'b1);
        send(32'd16777219,  1'b0, 32'h4B80_0002, 1'b1);
        send(32'h0100_0005, 1'b0, 32'h4B80_0002, 1'b1);
        send(32'hFFFF_FFFF, 1'b1, 32'h4F80_0000, 1'b1);
        send(32'hFFFF_FFFE, 1'b0, 32'hC000_0000, 1'b0);
        send(32'hFFFF_FFFE, 1'b1, 32'h4F80_0000, 1'b1);
        send(32'd0,         1'b1, 32'h0000_0000, 1'b0);
        drain();
        lat_en = 1'b0;

        // Backpressure: three accepts fill the pipe, then input stalls and output holds.
        out_ready = 1'b0;
        send_m(32'd100, 1'b0);
        send_m(32'hFFFF_FF9C, 1'b0);
        send_m(32'h7FFF_FFFF, 1'b0);
        x = 32'd12345;
        int_in = x; is_unsigned = 1'b1; in_valid = 1'b1;
        nxt_res = ref_conv(x, 1'b1); nxt_inx = 1'b0;
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        held = float_result;
        cycle();
        check("bp_no_accept", 64'(acc), 64'(0));
        check("bp_hold", 64'(float_result), 64'(held));
        out_ready = 1'b1;
        send_m(x, 1'b1);
        cycle();
        send_m(32'h0300_0003, 1'b0);
        drain();

        // A bubble in a stalled pipe is squeezed out, so one more input fits.
        out_ready = 1'b0;
        send_m(32'd3, 1'b0);
        cycle();
        send_m(32'hF000_0001, 1'b0);
        x = 32'h00FF_FFFF;
        int_in = x; is_unsigned = 1'b0; in_valid = 1'b1;
        nxt_res = ref_conv(x, 1'b0); nxt_inx = 1'b0;
        #1;
        check("bubble_in_ready", 64'(in_ready), 64'(1));
        cycle();
        check("bubble_accept", 64'(acc), 64'(1));
        in_valid = 1'b0;
        #1;
        check("full_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        drain();

        // Randomized traffic with random output stalls.
        rand_or = 1'b1;
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 3))
                0: x = $urandom;
                1: x = $urandom >> $urandom_range(0, 31);
                2: x = 32'h0100_0000 | 32'($urandom_range(0, 15));
                default: x = 32'h8000_0000 + 32'($urandom_range(0, 255));
            endcase
            send_m(x, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) cycle();
        end
        rand_or = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three items in flight: outputs clear at once, nothing stale follows.
        send_m(32'd1, 1'b0);
        send_m(32'd2, 1'b0);
        send_m(32'd3, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_result", 64'(float_result), 64'(0));
        exp_q.delete();
        in_valid = 1'b1; int_in = 32'd99;
        cycle();
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("midrst_idle", 64'(out_valid), 64'(0));
            cycle();
        end
        check("midrst_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
